// File: rtl/riscv_tag_check.sv
// DIFT tag policy check for the EX stage: flags policy violations, stalls EX,
// holds a security exception request until acked and counts violations.
module riscv_tag_check #(
    parameter int TAG_WIDTH = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    input  logic                 check_en_i,
    input  logic [1:0]           check_mode_i,
    input  logic [TAG_WIDTH-1:0] tag_result_i,
    input  logic [31:0]          pc_i,
    input  logic [TAG_WIDTH-1:0] policy_mask_i,
    input  logic                 exc_ack_i,
    input  logic                 clear_i,
    output logic                 stall_o,
    output logic                 exc_req_o,
    output logic [31:0]          exc_pc_o,
    output logic [TAG_WIDTH-1:0] exc_tag_o,
    output logic [CNT_WIDTH-1:0] viol_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_REQ   = 2'b01,
        S_BLANK = 2'b10
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [TAG_WIDTH-1:0]   w_masked;
    logic                   w_hit;
    logic                   w_det;
    logic [31:0]            r_exc_pc;
    logic [TAG_WIDTH-1:0]   r_exc_tag;
    logic [CNT_WIDTH-1:0]   r_cnt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Reserved mode 11 behaves like mode 00 (no check).
    always_comb begin
        w_masked = tag_result_i & policy_mask_i;
        w_hit    = 1'b0;
        case (check_mode_i)
            2'b01:   w_hit = |w_masked;
            2'b10:   w_hit = (policy_mask_i != '0) && (w_masked == policy_mask_i);
            default: w_hit = 1'b0;
        endcase
        w_det = (r_state == S_IDLE) && valid_i && check_en_i && w_hit;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_det) w_state_nxt = S_REQ;
            S_REQ:   if (exc_ack_i) w_state_nxt = S_BLANK;
            S_BLANK: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fault record holds until the next detection; ack does not clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exc_pc  <= '0;
            r_exc_tag <= '0;
        end else if (w_det) begin
            r_exc_pc  <= pc_i;
            r_exc_tag <= w_masked;
        end
    end

    // A clear coinciding with a detection wins: that violation is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (w_det) begin
            r_cnt <= sat_inc(r_cnt);
        end
    end

    assign stall_o    = w_det || (r_state == S_REQ);
    assign exc_req_o  = (r_state == S_REQ);
    assign exc_pc_o   = r_exc_pc;
    assign exc_tag_o  = r_exc_tag;
    assign viol_cnt_o = r_cnt;

endmodule

// File: tb/tb_riscv_tag_check.sv
// Self-checking bench for riscv_tag_check: scenario tasks plus a scoreboard
// of expected fault records popped whenever exc_req_o rises.
module tb_riscv_tag_check;

    localparam int TW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_i = 1'b0;
    logic          check_en_i = 1'b0;
    logic [1:0]    check_mode_i = 2'b00;
    logic [TW-1:0] tag_result_i = '0;
    logic [31:0]   pc_i = '0;
    logic [TW-1:0] policy_mask_i = '0;
    logic          exc_ack_i = 1'b0;
    logic          clear_i = 1'b0;
    logic          stall_o;
    logic          exc_req_o;
    logic [31:0]   exc_pc_o;
    logic [TW-1:0] exc_tag_o;
    logic [CW-1:0] viol_cnt_o;

    typedef struct {
        logic [31:0]   pc;
        logic [TW-1:0] tag;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    int            n_tests = 0;
    int            n_fail = 0;
    int            exp_cnt = 0;
    logic          prev_req = 1'b0;

    riscv_tag_check #(.TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .check_en_i(check_en_i),
        .check_mode_i(check_mode_i), .tag_result_i(tag_result_i), .pc_i(pc_i),
        .policy_mask_i(policy_mask_i), .exc_ack_i(exc_ack_i), .clear_i(clear_i),
        .stall_o(stall_o), .exc_req_o(exc_req_o), .exc_pc_o(exc_pc_o),
        .exc_tag_o(exc_tag_o), .viol_cnt_o(viol_cnt_o)
    );

    always #5 clk = ~clk;

    // Scoreboard: every rising exc_req_o must match the oldest expected fault.
    always @(negedge clk) begin
        exp_t e;
        if (exc_req_o === 1'b1 && prev_req === 1'b0) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_req: exc_req_o rose with no expected fault at %0t", $time);
            end else begin
                e = sb.pop_front();
                if (exc_pc_o !== e.pc || exc_tag_o !== e.tag || viol_cnt_o !== e.cnt) begin
                    n_fail++;
                    $display("FAIL sb_record: got pc=%h tag=%h cnt=%0d, want pc=%h tag=%h cnt=%0d",
                             exc_pc_o, exc_tag_o, viol_cnt_o, e.pc, e.tag, e.cnt);
                end
            end
        end
        prev_req = exc_req_o;
    end

    task automatic drv(input logic v, input logic en, input logic [1:0] m,
                       input logic [TW-1:0] t, input logic [TW-1:0] mk, input logic [31:0] p);
        valid_i       = v;
        check_en_i    = en;
        check_mode_i  = m;
        tag_result_i  = t;
        policy_mask_i = mk;
        pc_i          = p;
    endtask

    task automatic push_exp(input logic [31:0] p, input logic [TW-1:0] t);
        exp_t e;
        if (clear_i) exp_cnt = 0;
        else if (exp_cnt < (2**CW) - 1) exp_cnt++;
        e.pc  = p;
        e.tag = t;
        e.cnt = CW'(exp_cnt);
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({stall_o, exc_req_o, exc_pc_o, exc_tag_o, viol_cnt_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: stall=%b req=%b pc=%h tag=%h cnt=%0d, want all 0",
                     stall_o, exc_req_o, exc_pc_o, exc_tag_o, viol_cnt_o);
        end
        drv(1, 0, 2'b01, 4'hF, 4'hF, 32'h100);
        #1;
        n_tests++;
        if (stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_check_stall: stall_o=%b want 0", stall_o);
        end
        @(negedge clk);
        drv(0, 0, 2'b00, 4'h0, 4'h0, 32'h0);
        n_tests++;
        if (exc_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_check_req: exc_req_o=%b want 0", exc_req_o);
        end
    endtask

    task automatic test_any_set();
        @(negedge clk);
        drv(1, 1, 2'b01, 4'b0110, 4'b0100, 32'h0000_1F00);
        push_exp(32'h0000_1F00, 4'b0100);
        #1;
        n_tests++;
        if (stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL any_stall_N: stall_o=%b want 1", stall_o);
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            drv(0, 0, 2'b00, 4'h0, 4'h0, 32'h0);
            if (c == 3) exc_ack_i = 1'b1;
            n_tests++;
            if (exc_req_o !== 1'b1 || stall_o !== 1'b1) begin
                n_fail++;
                $display("FAIL any_req_N+%0d: req=%b stall=%b want 1 1", c, exc_req_o, stall_o);
            end
        end
        @(negedge clk);
        exc_ack_i = 1'b0;
        drv(1, 1, 2'b01, 4'b0110, 4'b0100, 32'h0000_2000);
        #1;
        n_tests++;
        if (exc_req_o !== 1'b0 || stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL any_blank: req=%b stall=%b want 0 0", exc_req_o, stall_o);
        end
        @(negedge clk);
        drv(0, 0, 2'b00, 4'h0, 4'h0, 32'h0);
        n_tests++;
        if (exc_req_o !== 1'b0 || exc_pc_o !== 32'h1F00 || exc_tag_o !== 4'b0100 || viol_cnt_o !== 4'd1) begin
            n_fail++;
            $display("FAIL any_idle_hold: req=%b pc=%h tag=%h cnt=%0d, want 0 1f00 4 1",
                     exc_req_o, exc_pc_o, exc_tag_o, viol_cnt_o);
        end
    endtask

    task automatic test_all_set();
        logic [1:0] modes[3];
        logic [TW-1:0] tags[3];
        logic [TW-1:0] masks[3];
        modes[0] = 2'b10; tags[0] = 4'b0001; masks[0] = 4'b0011;
        modes[1] = 2'b10; tags[1] = 4'hF;    masks[1] = 4'b0000;
        modes[2] = 2'b11; tags[2] = 4'hF;    masks[2] = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drv(1, 1, modes[i], tags[i], masks[i], 32'h3000 + i);
            #1;
            n_tests++;
            if (stall_o !== 1'b0) begin
                n_fail++;
                $display("FAIL allset_notrap_%0d: stall_o=%b want 0", i, stall_o);
            end
            @(negedge clk);
            drv(0, 0, 2'b00, 4'h0, 4'h0, 32'h0);
            n_tests++;
            if (exc_req_o !== 1'b0) begin
                n_fail++;
                $display("FAIL allset_noreq_%0d: exc_req_o=%b want 0", i, exc_req_o);
            end
        end
        @(negedge clk);
        drv(1, 1, 2'b10, 4'b1011, 4'b0011, 32'h0000_3F00);
        push_exp(32'h0000_3F00, 4'b0011);
        #1;
        n_tests++;
        if (stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL allset_trap_stall: stall_o=%b want 1", stall_o);
        end
        @(negedge clk);
        drv(0, 0, 2'b00, 4'h0, 4'h0, 32'h0);
        exc_ack_i = 1'b1;
        n_tests++;
        if (exc_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL allset_trap_req: exc_req_o=%b want 1", exc_req_o);
        end
        @(negedge clk);
        exc_ack_i = 1'b0;
        n_tests++;
        if (exc_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL allset_early_ack: exc_req_o=%b want 0", exc_req_o);
        end
        @(negedge clk);
    endtask

    task automatic test_suppression();
        @(negedge clk);
        drv(1, 1, 2'b01, 4'b1000, 4'b1000, 32'h0000_4000);
        push_exp(32'h0000_4000, 4'b1000);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            exc_ack_i = (c == 2);
            #1;
            n_tests++;
            if (stall_o !== 1'b1 || exc_req_o !== 1'b1) begin
                n_fail++;
                $display("FAIL supp_req_N+%0d: stall=%b req=%b want 1 1", c, stall_o, exc_req_o);
            end
        end
        @(negedge clk);
        exc_ack_i = 1'b0;
        #1;
        n_tests++;
        if (stall_o !== 1'b0 || viol_cnt_o !== CW'(exp_cnt)) begin
            n_fail++;
            $display("FAIL supp_blank: stall=%b cnt=%0d want 0 %0d", stall_o, viol_cnt_o, exp_cnt);
        end
        @(negedge clk);
        push_exp(32'h0000_4000, 4'b1000);
        #1;
        n_tests++;
        if (stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL supp_retrap_stall: stall_o=%b want 1", stall_o);
        end
        @(negedge clk);
        drv(0, 0, 2'b00, 4'h0, 4'h0, 32'h0);
        exc_ack_i = 1'b1;
        @(negedge clk);
        exc_ack_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_counter_sat();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drv(1, 1, 2'b01, 4'b0001, 4'b0001, 32'h5000 + i);
            push_exp(32'h5000 + i, 4'b0001);
            @(negedge clk);
            drv(0, 0, 2'b00, 4'h0, 4'h0, 32'h0);
            exc_ack_i = 1'b1;
            @(negedge clk);
            exc_ack_i = 1'b0;
        end
        n_tests++;
        if (viol_cnt_o !== 4'hF) begin
            n_fail++;
            $display("FAIL cnt_saturate: viol_cnt_o=%0d want 15", viol_cnt_o);
        end
    endtask

    task automatic test_clear_det();
        @(negedge clk);
        clear_i = 1'b1;
        drv(1, 1, 2'b01, 4'b0010, 4'b0010, 32'h0000_6000);
        push_exp(32'h0000_6000, 4'b0010);
        @(negedge clk);
        clear_i = 1'b0;
        drv(0, 0, 2'b00, 4'h0, 4'h0, 32'h0);
        n_tests++;
        if (exc_req_o !== 1'b1 || viol_cnt_o !== 4'd0) begin
            n_fail++;
            $display("FAIL clear_with_det: req=%b cnt=%0d want 1 0", exc_req_o, viol_cnt_o);
        end
        exc_ack_i = 1'b1;
        @(negedge clk);
        exc_ack_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drv(1, 1, 2'b01, 4'b0100, 4'b0100, 32'h0000_7000);
        push_exp(32'h0000_7000, 4'b0100);
        @(negedge clk);
        drv(0, 0, 2'b00, 4'h0, 4'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        n_tests++;
        if (exc_req_o !== 1'b0 || stall_o !== 1'b0 || viol_cnt_o !== 4'd0 || exc_pc_o !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: req=%b stall=%b cnt=%0d pc=%h want 0 0 0 0",
                     exc_req_o, stall_o, viol_cnt_o, exc_pc_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drv(1, 1, 2'b01, 4'b1000, 4'b1000, 32'h0000_7100);
        push_exp(32'h0000_7100, 4'b1000);
        #1;
        n_tests++;
        if (stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL async_idle_after: stall_o=%b want 1", stall_o);
        end
        @(negedge clk);
        drv(0, 0, 2'b00, 4'h0, 4'h0, 32'h0);
        exc_ack_i = 1'b1;
        @(negedge clk);
        exc_ack_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_any_set();
        test_all_set();
        test_suppression();
        test_counter_sat();
        test_clear_det();
        test_async_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected faults never raised, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
